serial_frame_rx: RTL and testbench

//   Receiving end of the team's serial frame link. It turns a one-bit line

---
 rtl/serial_frame_rx.sv | 117 +++++++++++
 tb/tb_serial_frame_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional parity, stop bit.
// Optional parity stage is enabled by defining the macro RX_PARITY_EN.
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_valid;
  logic                r_parity_err;
  logic                r_frame_err;

`ifdef RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic                r_perr;
`else
  logic                w_unused_par;
  assign w_unused_par = (PARITY_ODD != 0);
`endif

  // Everything advances only on bit_en; the strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      r_perr       <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (bit_en) begin
        case (r_state)
          S_IDLE: begin
            if (!rx_in) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
`ifdef RX_PARITY_EN
              r_perr  <= 1'b0;
`endif
            end
          end
          S_DATA: begin
            // LSB arrives first, so shifting right lands bit k at index k.
            r_shift <= {rx_in, r_shift[DATA_W-1:1]};
            r_cnt   <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
`ifdef RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
`ifdef RX_PARITY_EN
          S_PARITY: begin
            r_perr  <= ((^r_shift) ^ rx_in) != PAR_ODD;
            r_state <= S_STOP;
          end
`endif
          S_STOP: begin
            if (rx_in) begin
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
`ifdef RX_PARITY_EN
              r_parity_err <= r_perr;
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: vector table plus hand sequences, scoreboard on output pulses.
// Adapts frame length and parity expectations to whether RX_PARITY_EN is defined.
module tb_serial_frame_rx;

  localparam int DATA_W = 8;
  localparam int W      = DATA_W + 3;
`ifdef RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam int N_SAMP = DATA_W + 2 + int'(PAR_EN);

  logic              clk;
  logic              reset;
  logic              rx_in;
  logic              bit_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_last;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              par_flip;
    logic              stop;
    int                period;
    logic              b2b;
    logic              exp_dv;
    logic              exp_fe;
    logic              exp_pe;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  serial_frame_rx #(.DATA_W(DATA_W), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard: every output pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (data_valid || frame_err || parity_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({data_valid, frame_err, parity_err, data_out}), 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("scoreboard", 32'({data_valid, frame_err, parity_err, data_out}), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic drive_sample(input logic b, input int period);
    for (int k = 1; k < period; k++) begin
      @(negedge clk);
      bit_en = 1'b0;
      rx_in  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rx_in  = b;
    bit_en = 1'b1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic flip, input logic stop,
                            input int period, input logic tail,
                            input logic [W-1:0] exp);
    int start;
    start = cyc;
    exp_q.push_back(exp);
    drive_sample(1'b0, period);
    @(posedge clk);
    #1;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < DATA_W; i++) drive_sample(d[i], period);
    if (PAR_EN) drive_sample((^d) ^ flip, period);
    drive_sample(stop, period);
    if (tail) begin
      @(negedge clk);
      bit_en = 1'b0;
      rx_in  = 1'b1;
      check("pulse_timing", 32'({data_valid | frame_err, busy}), 32'b10);
      check("latency", 32'(cyc - start), 32'(N_SAMP * period + 1));
      @(negedge clk);
      check("pulse_width", 32'({data_valid, frame_err, parity_err}), 32'd0);
    end
  endtask

  initial begin
    // stimulus table: {data, par_flip, stop, period, b2b} -> expected outputs
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0,   8'hA5};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, PAR_EN, 8'hA5};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0,   8'hA5};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0,   8'h3C};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0,   8'hFF};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0, PAR_EN, 8'h00};
    vecs[6] = '{8'h81, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0,   8'h00};
    vecs[7] = '{8'h5A, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0,   8'h5A};
    vecs[8] = '{8'hC3, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, PAR_EN, 8'hC3};

    // reset with the line low and the strobe active
    reset  = 1'b1;
    rx_in  = 1'b0;
    bit_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_state",
            32'({busy, data_valid, frame_err, parity_err, data_out, dbg_state}), 32'd0);
    end
    reset  = 1'b0;
    rx_in  = 1'b1;
    bit_en = 1'b0;
    model_last = '0;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].data, vecs[v].par_flip, vecs[v].stop, vecs[v].period, !vecs[v].b2b,
                 {vecs[v].exp_dv, vecs[v].exp_fe, vecs[v].exp_pe, vecs[v].exp_data});
    end
    model_last = 8'hC3;
    check("data_out_hold", 32'(data_out), 32'(model_last));

    // reset in the middle of a frame aborts it silently
    drive_sample(1'b0, 1);
    for (int i = 0; i < 4; i++) drive_sample(1'($urandom_range(0, 1)), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_reset", 32'({busy, data_valid, frame_err, data_out, dbg_state}), 32'd0);
    reset  = 1'b0;
    rx_in  = 1'b1;
    bit_en = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle", 32'({busy, data_out}), 32'd0);
    bit_en = 1'b0;
    model_last = '0;
    send_frame(8'h01, 1'b0, 1'b1, 1, 1'b1, {1'b1, 1'b0, 1'b0, 8'h01});
    model_last = 8'h01;

    // random frames against the model
    for (int r = 0; r < 8; r++) begin
      logic [DATA_W-1:0] d;
      logic flip, stop;
      int per;
      d    = DATA_W'($urandom_range(0, 255));
      flip = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      per  = $urandom_range(1, 3);
      if (stop) begin
        send_frame(d, flip, stop, per, 1'b1, {1'b1, 1'b0, flip & PAR_EN, d});
        model_last = d;
      end else begin
        send_frame(d, flip, stop, per, 1'b1, {1'b0, 1'b1, 1'b0, model_last});
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
